// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code set 2 parser with a show-ahead key-event FIFO.
// Converts byte sequences (make, break, extended, Pause) into {ext, brk, code} events.
module ps2_kbd_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  output logic       rx_en,
  output logic       ev_valid,
  output logic [9:0] ev_data,
  input  logic       ev_rd,
  output logic       fifo_full,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       busy
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC);
  localparam int unsigned SKIP_W = 3;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t              state_q, state_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [9:0]          mem_q [FIFO_DEPTH];
  logic [9:0]          mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [9:0]          ev_data_q, ev_data_d;
  logic                ev_valid_q, ev_valid_d;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  logic                push;
  logic [9:0]          push_data;
  logic                pop, wr_en, drop, full_now;

  // Bytes that never form an event (BAT/echo/ack/error/resend responses).
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_discard = 1'b1;
      default:                                           is_discard = 1'b0;
    endcase
  endfunction

  // Parser next-state, skip counter, inter-byte timeout and event push.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    push      = 1'b0;
    push_data = '0;
    tmo_d     = (rx_done_tick || state_q == IDLE) ? '0 : tmo_q + TMO_W'(1);
    if (rx_done_tick) begin
      case (state_q)
        IDLE: begin
          if (rx_data == 8'hE0)       state_d = EXT;
          else if (rx_data == 8'hF0)  state_d = BRK;
          else if (rx_data == 8'hE1) begin
            state_d = SKIP;
            skip_d  = SKIP_W'(7);
          end else if (!is_discard(rx_data)) begin
            push      = 1'b1;
            push_data = {2'b00, rx_data};
          end
        end
        EXT: begin
          if (rx_data == 8'hF0)       state_d = EXT_BRK;
          else if (rx_data == 8'hE0)  state_d = EXT;
          else begin
            state_d = IDLE;
            if (!is_discard(rx_data)) begin
              push      = 1'b1;
              push_data = {2'b10, rx_data};
            end
          end
        end
        BRK, EXT_BRK: begin
          state_d = IDLE;
          if (!is_discard(rx_data) && rx_data != 8'hE0 &&
              rx_data != 8'hE1 && rx_data != 8'hF0) begin
            push      = 1'b1;
            push_data = {(state_q == EXT_BRK), 1'b1, rx_data};
          end
        end
        SKIP: begin
          skip_d = skip_q - SKIP_W'(1);
          if (skip_q == SKIP_W'(1)) begin
            state_d   = IDLE;
            push      = 1'b1;
            push_data = {2'b10, 8'hE1};
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
    end
  end

  // FIFO pointer/count update, registered head and sticky overflow.
  always_comb begin
    mem_d    = mem_q;
    full_now = (count_q == CNT_W'(FIFO_DEPTH));
    pop      = ev_rd && (count_q != '0);
    wr_en    = push && (!full_now || pop);
    drop     = push && full_now && !pop;
    if (wr_en) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ev_valid_d = (count_d != '0);
    full_d     = (count_d == CNT_W'(FIFO_DEPTH));
    ev_data_d  = ev_valid_d ? mem_d[rd_ptr_d] : ev_data_q;
    ovf_d      = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      skip_q     <= '0;
      tmo_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ev_data_q  <= '0;
      ev_valid_q <= 1'b0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ev_data_q  <= ev_data_d;
      ev_valid_q <= ev_valid_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
    end
  end

  assign rx_en     = ~full_q;
  assign ev_valid  = ev_valid_q;
  assign ev_data   = ev_data_q;
  assign fifo_full = full_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: parser sequences, FIFO full/overflow, timeout, reset.
module tb_ps2_kbd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       rx_en;
  logic       ev_valid;
  logic [9:0] ev_data;
  logic       ev_rd;
  logic       fifo_full;
  logic       overflow;
  logic       ovf_clr;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .rx_en(rx_en), .ev_valid(ev_valid), .ev_data(ev_data), .ev_rd(ev_rd),
    .fifo_full(fifo_full), .overflow(overflow), .ovf_clr(ovf_clr), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    step(1);
    rx_done_tick = 1'b0;
  endtask

  task automatic send_pop(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    ev_rd        = 1'b1;
    step(1);
    rx_done_tick = 1'b0;
    ev_rd        = 1'b0;
  endtask

  task automatic pop();
    ev_rd = 1'b1;
    step(1);
    ev_rd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rx_data = '0; rx_done_tick = 1'b0; ev_rd = 1'b0; ovf_clr = 1'b0;
    #2;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("rst_ev_valid", 32'(ev_valid), 32'h0);
    check("rst_ev_data", 32'(ev_data), 32'h0);
    check("rst_fifo_full", 32'(fifo_full), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rx_en", 32'(rx_en), 32'h1);
    check("rst_overflow", 32'(overflow), 32'h0);

    // make then break
    send(8'h1C);
    check("make_valid_latency", 32'(ev_valid), 32'h1);
    check("make_data", 32'(ev_data), 32'h01C);
    send(8'hF0);
    check("brk_busy", 32'(busy), 32'h1);
    send(8'h1C);
    check("brk_busy_done", 32'(busy), 32'h0);
    check("brk_head_still_make", 32'(ev_data), 32'h01C);
    pop();
    check("brk_valid", 32'(ev_valid), 32'h1);
    check("brk_data", 32'(ev_data), 32'h11C);
    pop();
    check("empty_valid", 32'(ev_valid), 32'h0);
    check("empty_hold_data", 32'(ev_data), 32'h11C);

    // extended make and extended break
    send(8'hE0);
    check("ext_busy", 32'(busy), 32'h1);
    send(8'h75);
    check("ext_busy_done", 32'(busy), 32'h0);
    check("ext_data", 32'(ev_data), 32'h275);
    send(8'hE0);
    send(8'hF0);
    check("extbrk_busy", 32'(busy), 32'h1);
    send(8'h75);
    check("extbrk_busy_done", 32'(busy), 32'h0);
    pop();
    check("extbrk_data", 32'(ev_data), 32'h375);
    pop();
    check("ext_drained", 32'(ev_valid), 32'h0);

    // Pause: E1 + 7 tail bytes -> one event
    send(8'hE1);
    check("pause_busy_e1", 32'(busy), 32'h1);
    send(8'h14); check("pause_busy_1", 32'(busy), 32'h1);
    send(8'h77); check("pause_busy_2", 32'(busy), 32'h1);
    send(8'hE1); check("pause_busy_3", 32'(busy), 32'h1);
    send(8'hF0); check("pause_busy_4", 32'(busy), 32'h1);
    send(8'h14); check("pause_busy_5", 32'(busy), 32'h1);
    send(8'hF0); check("pause_busy_6", 32'(busy), 32'h1);
    check("pause_no_early_ev", 32'(ev_valid), 32'h0);
    send(8'h77);
    check("pause_busy_end", 32'(busy), 32'h0);
    check("pause_valid", 32'(ev_valid), 32'h1);
    check("pause_data", 32'(ev_data), 32'h2E1);
    pop();
    check("pause_single", 32'(ev_valid), 32'h0);

    // fill FIFO, overflow on 5th
    send(8'h15); send(8'h16); send(8'h24);
    check("fill3_not_full", 32'(fifo_full), 32'h0);
    send(8'h25);
    check("full_flag", 32'(fifo_full), 32'h1);
    check("full_rx_en", 32'(rx_en), 32'h0);
    check("full_no_ovf", 32'(overflow), 32'h0);
    send(8'h2E);
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_head", 32'(ev_data), 32'h015);
    pop(); check("pop_16", 32'(ev_data), 32'h016);
    check("pop_rx_en", 32'(rx_en), 32'h1);
    pop(); check("pop_24", 32'(ev_data), 32'h024);
    pop(); check("pop_25", 32'(ev_data), 32'h025);
    pop(); check("pop_empty", 32'(ev_valid), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h1);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'h0);

    // push with simultaneous pop while full
    send(8'h15); send(8'h16); send(8'h24); send(8'h25);
    send_pop(8'h2E);
    check("pushpop_full", 32'(fifo_full), 32'h1);
    check("pushpop_no_ovf", 32'(overflow), 32'h0);
    check("pushpop_head", 32'(ev_data), 32'h016);
    pop(); pop(); pop();
    check("pushpop_last", 32'(ev_data), 32'h02E);
    pop();
    check("pushpop_drained", 32'(ev_valid), 32'h0);

    // timeout abandons pending break
    send(8'hF0);
    step(15);
    check("tmo_busy_before", 32'(busy), 32'h1);
    step(1);
    check("tmo_busy_after", 32'(busy), 32'h0);
    step(4);
    send(8'h1C);
    check("tmo_ev_valid", 32'(ev_valid), 32'h1);
    check("tmo_ev_make", 32'(ev_data), 32'h01C);
    pop();

    // discard codes
    send(8'hAA); send(8'hFA); send(8'hE0); send(8'hFA);
    check("discard_no_ev", 32'(ev_valid), 32'h0);
    check("discard_idle", 32'(busy), 32'h0);

    // reset mid-sequence with events queued
    send(8'h1D); send(8'h1E); send(8'hF0);
    check("pre_rst_busy", 32'(busy), 32'h1);
    do_reset();
    check("mid_rst_valid", 32'(ev_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_data", 32'(ev_data), 32'h0);
    send(8'h1C);
    check("post_rst_data", 32'(ev_data), 32'h01C);
    check("post_rst_valid", 32'(ev_valid), 32'h1);
    pop();
    check("post_rst_single", 32'(ev_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
